// File: rtl/lifo_stack_pkg.sv
// ---------------------------------------------------------------------------
// lifo_stack_pkg
//   Shared CPU stack definitions used by the register-stack datapath.
//   - OP_PUSH_R / OP_POP_R : decoder opcodes that map onto push / pop strobes
//   - DEFAULT_DATA_W / DEFAULT_DEPTH : default stack geometry
//   - stack_act_e : the single action the stack performs on a given edge
//   - decode_act() : resolves clear/push/pop/status into that action
// ---------------------------------------------------------------------------
package lifo_stack_pkg;

    // Decoder opcodes; the stack itself only sees the resulting strobes.
    localparam logic [5:0] OP_PUSH_R = 6'h2A;
    localparam logic [5:0] OP_POP_R  = 6'h2B;

    localparam int DEFAULT_DATA_W = 14;
    localparam int DEFAULT_DEPTH  = 12;

    typedef enum logic [2:0] {
        ACT_IDLE     = 3'd0,
        ACT_FLUSH    = 3'd1,
        ACT_PUSH     = 3'd2,
        ACT_PUSH_REJ = 3'd3,
        ACT_POP      = 3'd4,
        ACT_POP_REJ  = 3'd5,
        ACT_REPLACE  = 3'd6,
        ACT_BYPASS   = 3'd7
    } stack_act_e;

    // clear dominates; a combined push+pop never raises an error flag.
    function automatic stack_act_e decode_act(
        input logic clr,
        input logic psh,
        input logic pp,
        input logic is_empty,
        input logic is_full
    );
        stack_act_e act;
        if (clr) begin
            act = ACT_FLUSH;
        end else if (psh && pp) begin
            act = is_empty ? ACT_BYPASS : ACT_REPLACE;
        end else if (psh) begin
            act = is_full ? ACT_PUSH_REJ : ACT_PUSH;
        end else if (pp) begin
            act = is_empty ? ACT_POP_REJ : ACT_POP;
        end else begin
            act = ACT_IDLE;
        end
        return act;
    endfunction

endpackage : lifo_stack_pkg

// File: rtl/lifo_stack_mem.sv
// ---------------------------------------------------------------------------
// lifo_mem
//   DEPTH x DATA_W register array, one synchronous write port and one
//   asynchronous read port. Contents are deliberately not reset.
//   Ports:
//     clk   : write clock (rising edge)
//     we    : write enable
//     waddr : write address
//     wdata : write data
//     raddr : read address (asynchronous)
//     rdata : read data, 0 for an out-of-range address
// ---------------------------------------------------------------------------
module lifo_mem #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; out-of-range addresses are dropped (DEPTH need not be 2^n).
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Asynchronous read with a safe value for unused address codes.
    always_comb begin
        rdata = {DATA_W{1'b0}};
        if (int'(raddr) < DEPTH) begin
            rdata = mem_r[raddr];
        end else begin
            rdata = {DATA_W{1'b0}};
        end
    end

endmodule : lifo_mem

// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack
//   Parametrised LIFO stack for the CPU register-stack. Supports push, pop,
//   simultaneous push+pop (replace-top, or bypass when empty), synchronous
//   flush and sticky overflow/underflow flags.
//   Ports:
//     clk, reset : clock (rising edge) and asynchronous active-high reset
//     push, pop  : operation strobes
//     clear      : synchronous flush, overrides push/pop, clears error flags
//     push_data  : word to push
//     pop_data   : registered last popped word
//     pop_valid  : one-cycle pulse, pop_data updated on this edge
//     top        : combinational top entry (0 when empty)
//     count      : occupancy, empty / full derived from it
//     overflow   : sticky, a push was rejected
//     underflow  : sticky, a pop was rejected
// ---------------------------------------------------------------------------
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stack_act_e        act_s;

    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [DATA_W-1:0] pop_data_r;
    logic [DATA_W-1:0] pop_data_nxt_s;
    logic              pop_valid_r;
    logic              pop_valid_nxt_s;
    logic              overflow_r;
    logic              overflow_nxt_s;
    logic              underflow_r;
    logic              underflow_nxt_s;

    logic              empty_s;
    logic              full_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W-1:0] top_addr_s;
    logic [DATA_W-1:0] rd_data_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == CNT_W'(DEPTH));

    // Top-of-stack address; parked at 0 when empty (top is masked then anyway).
    always_comb begin
        top_addr_s = {ADDR_W{1'b0}};
        if (empty_s) begin
            top_addr_s = {ADDR_W{1'b0}};
        end else begin
            top_addr_s = ADDR_W'(count_r - CNT_W'(1));
        end
    end

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (wr_en_s),
        .waddr  (wr_addr_s),
        .wdata  (push_data),
        .raddr  (top_addr_s),
        .rdata  (rd_data_s)
    );

    // Resolve the strobes into exactly one action for this edge.
    always_comb begin
        act_s = decode_act(clear, push, pop, empty_s, full_s);
    end

    // Next-state for count, pop path, error flags and the memory write port.
    // rd_data_s is the pre-edge top, so replace-top pops the old word while
    // the same slot is overwritten at the edge.
    always_comb begin
        count_nxt_s     = count_r;
        pop_data_nxt_s  = pop_data_r;
        pop_valid_nxt_s = 1'b0;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        wr_en_s         = 1'b0;
        wr_addr_s       = top_addr_s;

        case (act_s)
            ACT_FLUSH: begin
                count_nxt_s     = {CNT_W{1'b0}};
                overflow_nxt_s  = 1'b0;
                underflow_nxt_s = 1'b0;
            end
            ACT_PUSH: begin
                // count < DEPTH here, so it always fits the address width.
                wr_en_s     = 1'b1;
                wr_addr_s   = ADDR_W'(count_r);
                count_nxt_s = count_r + CNT_W'(1);
            end
            ACT_PUSH_REJ: begin
                overflow_nxt_s = 1'b1;
            end
            ACT_POP: begin
                pop_data_nxt_s  = rd_data_s;
                pop_valid_nxt_s = 1'b1;
                count_nxt_s     = count_r - CNT_W'(1);
            end
            ACT_POP_REJ: begin
                underflow_nxt_s = 1'b1;
            end
            ACT_REPLACE: begin
                pop_data_nxt_s  = rd_data_s;
                pop_valid_nxt_s = 1'b1;
                wr_en_s         = 1'b1;
                wr_addr_s       = top_addr_s;
            end
            ACT_BYPASS: begin
                // Nothing stored; the pushed word goes straight out.
                pop_data_nxt_s  = push_data;
                pop_valid_nxt_s = 1'b1;
            end
            ACT_IDLE: begin
                pop_valid_nxt_s = 1'b0;
            end
            default: begin
                count_nxt_s     = count_r;
                pop_valid_nxt_s = 1'b0;
                wr_en_s         = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r     <= {CNT_W{1'b0}};
            pop_data_r  <= {DATA_W{1'b0}};
            pop_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            pop_data_r  <= pop_data_nxt_s;
            pop_valid_r <= pop_valid_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    assign pop_data  = pop_data_r;
    assign pop_valid = pop_valid_r;
    assign count     = count_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    // Driven only by count and storage; push_data never reaches top.
    assign top       = empty_s ? {DATA_W{1'b0}} : rd_data_s;

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack
//   Self-checking bench for lifo_stack with default geometry. A queue-based
//   model tracks the stack; every negedge compares all outputs against it.
//   Directed scenarios add literal expectations, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_lifo_stack;

    localparam int DATA_W = 14;
    localparam int DEPTH  = 12;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              push;
    logic              pop;
    logic              clear;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [DATA_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int errors = 0;
    int checks = 0;

    // Behavioural model
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_pop_data;
    logic              m_pop_valid;
    logic              m_ovf;
    logic              m_unf;

    lifo_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (push_data),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_pop_data  = '0;
        m_pop_valid = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
    endfunction

    function automatic void model_edge(input logic pu, input logic po, input logic cl,
                                       input logic [DATA_W-1:0] d);
        m_pop_valid = 1'b0;
        if (cl) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pu && po) begin
            m_pop_valid = 1'b1;
            if (m_q.size() == 0) begin
                m_pop_data = d;
            end else begin
                m_pop_data = m_q[m_q.size()-1];
                m_q[m_q.size()-1] = d;
            end
        end else if (pu) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (m_q.size() > 0) begin
                m_pop_data  = m_q.pop_back();
                m_pop_valid = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end
    endfunction

    function automatic logic [DATA_W-1:0] model_top();
        return (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("count",     32'(count),     32'(m_q.size()));
        chk("empty",     32'(empty),     32'(m_q.size() == 0));
        chk("full",      32'(full),      32'(m_q.size() == DEPTH));
        chk("top",       32'(top),       32'(model_top()));
        chk("pop_valid", 32'(pop_valid), 32'(m_pop_valid));
        chk("pop_data",  32'(pop_data),  32'(m_pop_data));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    end

    // Apply one cycle of stimulus; returns at negedge+1 with outputs settled.
    task automatic step(input logic pu, input logic po, input logic cl,
                        input logic [DATA_W-1:0] d);
        push      = pu;
        pop       = po;
        clear     = cl;
        push_data = d;
        @(posedge clk);
        if (!reset) model_edge(pu, po, cl, d);
        @(negedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        push_data = '0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_top",   32'(top),   32'd0);

        // Pop on empty: underflow sticks through idle cycles
        step(1'b0, 1'b1, 1'b0, 14'h0);
        chk("unf_set",  32'(underflow), 32'd1);
        chk("unf_pv",   32'(pop_valid), 32'd0);
        chk("unf_pd",   32'(pop_data),  32'd0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 14'h0);
        chk("unf_sticky", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 14'h0);
        chk("unf_clear", 32'(underflow), 32'd0);

        // Push 1,2,3 then pop them back
        step(1'b1, 1'b0, 1'b0, 14'h001);
        step(1'b1, 1'b0, 1'b0, 14'h002);
        step(1'b1, 1'b0, 1'b0, 14'h003);
        chk("p3_count", 32'(count), 32'd3);
        chk("p3_top",   32'(top),   32'h003);
        step(1'b0, 1'b1, 1'b0, 14'h0);
        chk("pop1_pd", 32'(pop_data), 32'h003);
        chk("pop1_pv", 32'(pop_valid), 32'd1);
        chk("pop1_top", 32'(top), 32'h002);
        step(1'b0, 1'b1, 1'b0, 14'h0);
        chk("pop2_pd", 32'(pop_data), 32'h002);
        step(1'b0, 1'b1, 1'b0, 14'h0);
        chk("pop3_pd", 32'(pop_data), 32'h001);
        chk("pop3_pv", 32'(pop_valid), 32'd1);
        chk("pop3_empty", 32'(empty), 32'd1);
        chk("pop3_top", 32'(top), 32'd0);

        // Replace-top at count 4
        step(1'b1, 1'b0, 1'b0, 14'h011);
        step(1'b1, 1'b0, 1'b0, 14'h022);
        step(1'b1, 1'b0, 1'b0, 14'h033);
        step(1'b1, 1'b0, 1'b0, 14'h0AA);
        step(1'b1, 1'b1, 1'b0, 14'h155);
        chk("rep_pd",    32'(pop_data), 32'h0AA);
        chk("rep_top",   32'(top),      32'h155);
        chk("rep_count", 32'(count),    32'd4);

        // Fill to full, replace-top when full, then rejected push
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 14'(14'h100 + i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd12);
        step(1'b1, 1'b1, 1'b0, 14'h2AA);
        chk("repf_pd",  32'(pop_data), 32'h107);
        chk("repf_top", 32'(top),      32'h2AA);
        chk("repf_ovf", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 1'b0, 14'h3FFF);
        chk("ovf_count", 32'(count),    32'd12);
        chk("ovf_top",   32'(top),      32'h2AA);
        chk("ovf_set",   32'(overflow), 32'd1);
        step(1'b1, 1'b1, 1'b1, 14'h0);
        chk("clr_count", 32'(count),     32'd0);
        chk("clr_ovf",   32'(overflow),  32'd0);
        chk("clr_pv",    32'(pop_valid), 32'd0);
        chk("clr_pd",    32'(pop_data),  32'h107);

        // Bypass on empty
        step(1'b1, 1'b1, 1'b0, 14'h123);
        chk("byp_pd",    32'(pop_data),  32'h123);
        chk("byp_pv",    32'(pop_valid), 32'd1);
        chk("byp_count", 32'(count),     32'd0);
        chk("byp_unf",   32'(underflow), 32'd0);

        // Randomized phases alternating push-heavy and pop-heavy
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 250; c++) begin
                int pw;
                pw = (ph % 2 == 0) ? 75 : 25;
                step(1'(($urandom_range(0, 99)) < pw),
                     1'(($urandom_range(0, 99)) < (100 - pw)),
                     1'(($urandom_range(0, 99)) < 2),
                     14'($urandom));
            end
        end

        // Async reset mid-cycle with push held
        step(1'b0, 1'b0, 1'b1, 14'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 14'(14'h050 + i));
        step(1'b0, 1'b1, 1'b0, 14'h0);
        chk("pre_rst_count", 32'(count), 32'd4);
        push      = 1'b1;
        push_data = 14'h077;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_empty", 32'(empty),     32'd1);
        chk("arst_full",  32'(full),      32'd0);
        chk("arst_top",   32'(top),       32'd0);
        chk("arst_pd",    32'(pop_data),  32'd0);
        chk("arst_pv",    32'(pop_valid), 32'd0);
        chk("arst_ovf",   32'(overflow),  32'd0);
        chk("arst_unf",   32'(underflow), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_edge_count", 32'(count), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 14'h0);
        chk("post_rst_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lifo_stack

// File: doc/lifo_stack.md
# lifo_stack

Parametrised hardware LIFO stack: the next generation of the CPU's register-stack. It adds arbitrary depth and width, independent push/pop strobes with simultaneous push+pop (replace-top), full/empty/count status, a combinational top-of-stack view and sticky overflow/underflow error flags. It sits beside the register file in the CPU datapath and is driven by the instruction decoder on `OP_PUSH_R` / `OP_POP_R`.

## Interface
Parameters:
- `DATA_W`, 14, word width.
- `DEPTH`, 12, number of entries (≥2, any value, not restricted to a power of two).
- `CNT_W`, `$clog2(DEPTH+1)`, localparam, width of the occupancy count.

Ports:
- Clock and reset: one clock, `clk`; `reset` is asynchronous and active-high.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `push` input 1: push request.
- `pop` input 1: pop request.
- `clear` input 1: synchronous flush.
- `push_data` input DATA_W: word to push.
- `pop_data` output DATA_W: registered last popped word.
- `pop_valid` output 1: one-cycle pulse; `pop_data` was updated on this edge.
- `top` output DATA_W: current top entry, combinational from storage; 0 when empty.
- `count` output CNT_W: number of entries held.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == DEPTH`.
- `overflow` output 1: sticky; a push was rejected.
- `underflow` output 1: sticky; a pop was rejected.

## Operation
- Reset values: `count=0`, `pop_data=0`, `pop_valid=0`, `overflow=0`, `underflow=0`, so `empty=1`, `full=0`, `top=0`. Storage contents are not reset.
- Per-edge priority: `clear` > push/pop.
- `clear`:
  - sets `count=0` and clears `overflow` and `underflow`;
  - leaves `pop_data` unchanged and holds `pop_valid=0`;
  - ignores `push` and `pop` issued in the same cycle.
- Push only:
  - not full: write `push_data` to `mem[count]` and increment `count`.
  - full: nothing is written, `count` holds, `overflow` is set.
- Pop only:
  - not empty: `pop_data <= mem[count-1]`, decrement `count`, pulse `pop_valid`.
  - empty: `pop_data` holds, `pop_valid=0`, `underflow` is set.
- Push and pop in the same cycle:
  - not empty (including full): replace-top. `pop_data <= mem[count-1]`, `mem[count-1] <= push_data`, `count` unchanged, `pop_valid=1`, no error flag.
  - empty: bypass. `pop_data <= push_data`, `pop_valid=1`, `count` stays 0, nothing is written, no error.
- `overflow` and `underflow` stay set until `clear` or `reset`.
- `count` never wraps. It is bounded to 0..DEPTH in all cases.
- Reset mid-operation: an asynchronous assertion forces the reset values immediately; the in-flight operation is lost.

## Timing
- All state updates on the rising edge of `clk`; `reset` acts asynchronously.
- Push at edge N: `count`, `empty`, `full` and `top` reflect the new word after edge N. Latency is 1 cycle; back-to-back pushes are accepted every cycle.
- Pop at edge N: `pop_data` and `pop_valid` are valid in the cycle after edge N. `top` shows the next entry in that same cycle.
- `top` is combinational from `count` and storage only; there is no path from `push_data` to `top`.
- Sustained throughput: one operation per cycle; replace-top is also a single cycle.

## Structure
- Shared CPU definitions package holds the stack op encodings (`OP_PUSH_R`, `OP_POP_R`) and the default `DATA_W`/`DEPTH` constants. The decoder maps opcodes to `push`/`pop`; this block has no opcode input.
- Sub-module `lifo_mem`: DEPTH×DATA_W register array with one synchronous write port and one asynchronous read port (address `count-1`).
- Pointer, flag and `pop_data` logic lives in `lifo_stack`.

## Test plan
All scenarios use the defaults (`DATA_W=14`, `DEPTH=12`).
- Reset, then push 0x001, 0x002, 0x003 on consecutive cycles:
  - `count=3`, `top=0x003`.
  - Pop ×3 gives `pop_data` 0x003, 0x002, 0x001 with `pop_valid` on each; then `empty=1`, `top=0`.
- Fill to 12 entries:
  - `full=1`.
  - A 13th push of 0x3FFF leaves `count=12` and `top` unchanged, and sets `overflow`.
  - `clear` gives `count=0` and `overflow=0`.
- Pop on empty after reset: `underflow=1`, `pop_valid=0`, `pop_data=0`. The flag stays set across 5 further idle cycles.
- With `top=0x0AA` and `count=4`, push 0x155 and pop together: `pop_data=0x0AA`, `top=0x155`, `count=4`. Repeat the same when full: no `overflow`.
- Empty, push 0x123 and pop together: `pop_data=0x123`, `pop_valid=1`, `count=0`, no `underflow`.
- Push 5 entries, then assert `reset` asynchronously mid-cycle together with `push`: all outputs go to their reset values before the next edge, and `count` stays 0 after that edge.
